// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard unit: one tracked pipeline slot and its tag match.
// Slot fields use fixed maximum widths so parameterised users can zero-extend into them.
package fwd_pkg;

   localparam int MAX_SRC   = 8;
   localparam int MAX_REG_W = 8;
   localparam int FWD_RF    = 0;

   typedef logic [MAX_REG_W-1:0] reg_addr_t;

   typedef struct packed {
      logic                        valid;
      logic                        wr;
      reg_addr_t                   dst;
      logic                        is_load;
      reg_addr_t [MAX_SRC-1:0]     src;
      logic      [MAX_SRC-1:0]     used;
   } slot_t;

   function automatic logic match(slot_t s, reg_addr_t addr);
      return s.valid && s.wr && (s.dst == addr);
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Issue-side bundle between the ID stage and the forwarding/hazard unit.
interface fwd_hazard_unit_if #(
   parameter int NUM_SRC = 2,
   parameter int REG_W   = 5,
   parameter int DEPTH   = 3,
   parameter int CNT_W   = 32,
   parameter int SEL_W   = $clog2(DEPTH)
);
   logic                     id_valid;
   logic [NUM_SRC*REG_W-1:0] id_src;
   logic [NUM_SRC-1:0]       id_src_used;
   logic [REG_W-1:0]         id_dst;
   logic                     id_wr;
   logic                     id_is_load;
   logic                     id_is_mul;
   logic                     flush;
   logic                     stall;
   logic                     ex_busy;
   logic [NUM_SRC*SEL_W-1:0] fwd_sel;
   logic [CNT_W-1:0]         stall_count;

   modport master (
      output id_valid, id_src, id_src_used, id_dst, id_wr, id_is_load, id_is_mul, flush,
      input  stall, ex_busy, fwd_sel, stall_count
   );

   modport slave (
      input  id_valid, id_src, id_src_used, id_dst, id_wr, id_is_load, id_is_mul, flush,
      output stall, ex_busy, fwd_sel, stall_count
   );
endinterface

// File: rtl/fwd_prio_sel.sv
// Youngest-first forward select for one EX operand over slots 2..DEPTH.
module fwd_prio_sel
   import fwd_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int SEL_W = 2
) (
   input  reg_addr_t        src,
   input  logic             en,
   input  slot_t            older [2:DEPTH],
   output logic [SEL_W-1:0] sel
);

   // Walk oldest to youngest so the youngest matching writer overrides.
   always_comb begin
      sel = SEL_W'(FWD_RF);
      if (en && (src != '0)) begin
         for (int k = DEPTH; k >= 2; k--) begin
            if (match(older[k], src)) sel = SEL_W'(k - 1);
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: shadow tag pipeline from EX onward, load-use and multiply
// stalls, per-operand forward selects and a saturating stall counter.
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int REG_W   = 5,
   parameter int DEPTH   = 3,
   parameter int MUL_LAT = 3,
   parameter int CNT_W   = 32,
   parameter int SEL_W   = $clog2(DEPTH)
) (
   input logic               clk,
   input logic               rst_n,
   fwd_hazard_unit_if.slave  bus
);

   localparam int MC_W = (MUL_LAT > 1) ? $clog2(MUL_LAT + 1) : 1;

   slot_t            slot_q [1:DEPTH];
   slot_t            slot_d [1:DEPTH];
   slot_t            older  [2:DEPTH];
   slot_t            id_slot;
   logic [MC_W-1:0]  mul_q, mul_d;
   logic [CNT_W-1:0] cnt_q;
   logic             ex_busy, load_use, stall, src_hit;
   wire  [SEL_W-1:0] sel_all [NUM_SRC];

   always_comb begin
      id_slot         = '0;
      id_slot.valid   = 1'b1;
      id_slot.wr      = bus.id_wr;
      id_slot.dst     = reg_addr_t'(bus.id_dst);
      id_slot.is_load = bus.id_is_load;
      for (int i = 0; i < NUM_SRC; i++) begin
         id_slot.src[i]  = reg_addr_t'(bus.id_src[i*REG_W +: REG_W]);
         id_slot.used[i] = bus.id_src_used[i];
      end
   end

   // Load in EX whose result the ID instruction reads: one bubble needed.
   always_comb begin
      src_hit = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (id_slot.used[i] && (id_slot.src[i] == slot_q[1].dst)) src_hit = 1'b1;
      end
      load_use = bus.id_valid && slot_q[1].valid && slot_q[1].is_load && slot_q[1].wr &&
                 (slot_q[1].dst != '0) && src_hit;
   end

   assign ex_busy = (mul_q != '0);
   assign stall   = load_use | ex_busy;

   always_comb begin
      slot_d[1] = slot_q[1];
      slot_d[2] = slot_q[1];
      for (int k = 3; k <= DEPTH; k++) slot_d[k] = slot_q[k-1];
      mul_d = mul_q;
      if (ex_busy) begin
         slot_d[2] = '0;
         mul_d     = mul_q - MC_W'(1);
      end else if (bus.flush || stall || !bus.id_valid) begin
         slot_d[1] = '0;
      end else begin
         slot_d[1] = id_slot;
         if (bus.id_is_mul) mul_d = MC_W'(MUL_LAT - 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 1; k <= DEPTH; k++) slot_q[k] <= '0;
         mul_q <= '0;
         cnt_q <= '0;
      end else begin
         slot_q <= slot_d;
         mul_q  <= mul_d;
         if (stall && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      for (int k = 2; k <= DEPTH; k++) older[k] = slot_q[k];
   end

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_prio_sel #(
         .DEPTH (DEPTH),
         .SEL_W (SEL_W)
      ) u_sel (
         .src   (slot_q[1].src[i]),
         .en    (slot_q[1].valid && slot_q[1].used[i]),
         .older (older),
         .sel   (sel_all[i])
      );
   end

   always_comb begin
      bus.fwd_sel = '0;
      for (int i = 0; i < NUM_SRC; i++) bus.fwd_sel[i*SEL_W +: SEL_W] = sel_all[i];
   end

   assign bus.stall       = stall;
   assign bus.ex_busy     = ex_busy;
   assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed and randomised bench for fwd_hazard_unit against an instruction-queue model.
module tb_fwd_hazard_unit;

   localparam int NUM_SRC = 2;
   localparam int REG_W   = 5;
   localparam int DEPTH   = 3;
   localparam int MUL_LAT = 3;
   localparam int CNT_W   = 2;
   localparam int SEL_W   = $clog2(DEPTH);
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fwd_hazard_unit_if #(.NUM_SRC(NUM_SRC), .REG_W(REG_W), .DEPTH(DEPTH),
                        .CNT_W(CNT_W), .SEL_W(SEL_W)) bus ();

   fwd_hazard_unit #(.NUM_SRC(NUM_SRC), .REG_W(REG_W), .DEPTH(DEPTH), .MUL_LAT(MUL_LAT),
                     .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      bit v;
      bit wr;
      int dst;
      bit ld;
      int src [2];
      bit used [2];
   } ins_t;

   ins_t pipe [3];   // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
   ins_t cur;
   ins_t bub;
   bit   cur_v, cur_mul, cur_fl;
   int   mul_left, cnt_m;
   int   n_vec, n_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int fsel(int i);
      return int'(bus.fwd_sel[i*SEL_W +: SEL_W]);
   endfunction

   function automatic bit m_lu();
      bit hit = 0;
      if (!cur_v || !pipe[0].v || !pipe[0].ld || !pipe[0].wr || pipe[0].dst == 0) return 0;
      for (int i = 0; i < 2; i++) if (cur.used[i] && cur.src[i] == pipe[0].dst) hit = 1;
      return hit;
   endfunction

   // Operand in EX takes the result of the youngest older writer of the same register.
   function automatic int m_fwd(int i);
      if (!pipe[0].v || !pipe[0].used[i] || pipe[0].src[i] == 0) return 0;
      for (int k = 1; k < 3; k++)
         if (pipe[k].v && pipe[k].wr && pipe[k].dst == pipe[0].src[i]) return k;
      return 0;
   endfunction

   task automatic drive(bit v, int s0, bit u0, int s1, bit u1, int dst, bit wr,
                        bit ld, bit mul, bit fl);
      cur_v = v; cur_mul = mul; cur_fl = fl;
      cur.v = 1; cur.wr = wr; cur.dst = dst; cur.ld = ld;
      cur.src[0] = s0; cur.src[1] = s1; cur.used[0] = u0; cur.used[1] = u1;
      bus.id_valid    = v;
      bus.id_src      = {REG_W'(s1), REG_W'(s0)};
      bus.id_src_used = {u1, u0};
      bus.id_dst      = REG_W'(dst);
      bus.id_wr       = wr;
      bus.id_is_load  = ld;
      bus.id_is_mul   = mul;
      bus.flush       = fl;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) pipe[k] = bub;
      mul_left = 0;
      cnt_m    = 0;
   endtask

   task automatic step(input string tag);
      bit busy, st;
      @(negedge clk);
      busy = (mul_left != 0);
      st   = busy | m_lu();
      chk({tag, ".stall"}, 32'(bus.stall), 32'(st));
      chk({tag, ".busy"},  32'(bus.ex_busy), 32'(busy));
      chk({tag, ".sel0"},  32'(fsel(0)), 32'(m_fwd(0)));
      chk({tag, ".sel1"},  32'(fsel(1)), 32'(m_fwd(1)));
      chk({tag, ".cnt"},   32'(bus.stall_count), 32'(cnt_m));
      pipe[2] = pipe[1];
      if (busy) begin
         pipe[1] = bub;
         mul_left--;
      end else begin
         pipe[1] = pipe[0];
         if (cur_fl || st || !cur_v) pipe[0] = bub;
         else begin
            pipe[0] = cur;
            if (cur_mul) mul_left = MUL_LAT - 1;
         end
      end
      if (st && cnt_m < CNT_MAX) cnt_m++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("rst.stall", 32'(bus.stall), 0);
      chk("rst.busy",  32'(bus.ex_busy), 0);
      chk("rst.sel",   32'(bus.fwd_sel), 0);
      chk("rst.cnt",   32'(bus.stall_count), 0);
      model_reset();
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      bub = '{default: 0};
      model_reset();
      idle();
      #12 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // back-to-back ALU dependency
      drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0); step("b2b.add");
      drive(1, 5, 1, 5, 1, 6, 1, 0, 0, 0); step("b2b.sub");
      idle(); #1;
      chk("b2b.sel0", 32'(fsel(0)), 1);
      chk("b2b.sel1", 32'(fsel(1)), 1);
      chk("b2b.stall", 32'(bus.stall), 0);
      step("b2b.ex");

      // youngest writer wins, x0 never forwards
      drive(1, 1, 1, 2, 1, 7, 1, 0, 0, 0); step("yw.i1");
      drive(1, 3, 1, 4, 1, 7, 1, 0, 0, 0); step("yw.i2");
      drive(1, 7, 1, 7, 1, 8, 1, 0, 0, 0); step("yw.i3");
      idle(); #1;
      chk("yw.sel0", 32'(fsel(0)), 1);
      chk("yw.sel1", 32'(fsel(1)), 1);
      drive(1, 1, 1, 1, 1, 0, 1, 0, 0, 0); step("x0.wr");
      drive(1, 0, 1, 0, 1, 9, 1, 0, 0, 0); step("x0.rd");
      idle(); #1;
      chk("x0.sel0", 32'(fsel(0)), 0);
      chk("x0.sel1", 32'(fsel(1)), 0);
      step("x0.ex");

      // asynchronous reset with the shadow pipeline full
      do_reset();

      // load-use
      drive(1, 2, 1, 0, 0, 3, 1, 1, 0, 0); step("lu.lw");
      drive(1, 3, 1, 1, 1, 4, 1, 0, 0, 0); #1;
      chk("lu.stall1", 32'(bus.stall), 1);
      step("lu.hold");
      chk("lu.stall0", 32'(bus.stall), 0);
      step("lu.issue");
      idle(); #1;
      chk("lu.sel0", 32'(fsel(0)), 2);
      chk("lu.sel1", 32'(fsel(1)), 0);
      chk("lu.cnt",  32'(bus.stall_count), 1);
      step("lu.ex");

      // multiply occupancy
      do_reset();
      drive(1, 1, 1, 2, 1, 9, 1, 0, 1, 0); step("mul.issue");
      drive(1, 9, 1, 0, 1, 10, 1, 0, 0, 0); #1;
      chk("mul.busy1", 32'(bus.ex_busy), 1);
      step("mul.b1");
      chk("mul.busy2", 32'(bus.ex_busy), 1);
      step("mul.b2");
      chk("mul.busy0", 32'(bus.ex_busy), 0);
      step("mul.dep");
      idle(); #1;
      chk("mul.sel0", 32'(fsel(0)), 1);
      chk("mul.sel1", 32'(fsel(1)), 0);
      chk("mul.cnt",  32'(bus.stall_count), 2);
      step("mul.ex");

      // flush during multiply, then counter saturation
      do_reset();
      drive(1, 1, 1, 2, 1, 11, 1, 0, 1, 0); step("fl.mul");
      drive(1, 11, 1, 11, 1, 12, 1, 0, 0, 1); step("fl.b1");
      step("fl.b2");
      step("fl.drop");
      idle(); #1;
      chk("fl.sel0", 32'(fsel(0)), 0);
      chk("fl.sel1", 32'(fsel(1)), 0);
      step("fl.idle");
      drive(1, 1, 1, 2, 1, 13, 1, 0, 1, 0); step("sat.mul");
      idle(); step("sat.b1"); step("sat.b2");
      drive(1, 2, 1, 0, 0, 14, 1, 1, 0, 0); step("sat.lw");
      drive(1, 14, 1, 0, 0, 15, 1, 0, 0, 0); step("sat.lu");
      idle(); #1;
      chk("sat.cnt", 32'(bus.stall_count), CNT_MAX);
      step("sat.end");

      // randomised traffic, small register set to provoke hazards
      do_reset();
      for (int n = 0; n < 400; n++) begin
         bit ld, mul;
         ld  = ($urandom_range(0, 3) == 0);
         mul = !ld && ($urandom_range(0, 6) == 0);
         drive($urandom_range(0, 9) < 7,
               $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7), 1'($urandom),
               $urandom_range(0, 7), $urandom_range(0, 4) != 0, ld, mul,
               $urandom_range(0, 9) == 0);
         step("rnd");
         if (n == 200) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
